// File: rtl/modexp_pkg.sv
// Shared constants, FSM state type and helpers for the modexp arbiter and engine wrapper.
package modexp_pkg;

    localparam int MODEXP_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } modexp_state_e;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/modexp_arbiter_if.sv
// Requester, engine and response signals of the modexp arbiter, grouped with master/slave views.
interface modexp_arbiter_if
    import modexp_pkg::*;
#(
    parameter int BITS = MODEXP_BITS_DEFAULT,
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] req_m;
    logic [NREQ*BITS-1:0] req_e;
    logic [NREQ*BITS-1:0] req_n;
    logic [NREQ-1:0]      ack;
    logic                 eng_go;
    logic [BITS-1:0]      eng_m;
    logic [BITS-1:0]      eng_e;
    logic [BITS-1:0]      eng_n;
    logic [BITS-1:0]      eng_r;
    logic                 eng_d;
    logic                 rsp_valid;
    logic [IW-1:0]        rsp_id;
    logic [BITS-1:0]      rsp_r;
    logic                 rsp_ready;
    logic                 err;

    modport master (
        output req, req_m, req_e, req_n, eng_r, eng_d, rsp_ready,
        input  ack, eng_go, eng_m, eng_e, eng_n, rsp_valid, rsp_id, rsp_r, err
    );

    modport slave (
        input  req, req_m, req_e, req_n, eng_r, eng_d, rsp_ready,
        output ack, eng_go, eng_m, eng_e, eng_n, rsp_valid, rsp_id, rsp_r, err
    );

endinterface

// File: rtl/modexp_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first active request at or after the pointer.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] idx_s;
    logic          found_s;

    // Walk the requesters from the pointer, wrapping at NREQ, and keep the first hit.
    always_comb begin
        gnt_o   = {NREQ{1'b0}};
        found_s = 1'b0;
        idx_s   = ptr_i;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
            if (idx_s == PW'(NREQ - 1)) begin
                idx_s = {PW{1'b0}};
            end else begin
                idx_s = idx_s + PW'(1);
            end
        end
    end

endmodule

// File: rtl/modexp_arbiter.sv
// Shares one modular-exponentiation engine among NREQ requesters, one job in flight.
// Optional engine watchdog enabled by defining MODEXP_ARB_TIMEOUT_EN.
module modexp_arbiter
    import modexp_pkg::*;
#(
    parameter int BITS       = MODEXP_BITS_DEFAULT,
    parameter int NREQ       = 4,
    parameter int TMO_CYCLES = 255
) (
    input logic             clk,
    input logic             reset_n,
    modexp_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    modexp_state_e   state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, rsp_id_q, rsp_id_d, win_idx_s;
    logic [NREQ-1:0] gnt_s, ack_q, ack_d;
    logic            eng_go_q, eng_go_d, rsp_valid_q, rsp_valid_d;
    logic [BITS-1:0] eng_m_q, eng_m_d, eng_e_q, eng_e_d, eng_n_q, eng_n_d, rsp_r_q, rsp_r_d;
    logic [BITS-1:0] m_s [NREQ];
    logic [BITS-1:0] e_s [NREQ];
    logic [BITS-1:0] n_s [NREQ];
    logic            any_req_s, hs_s, tmo_s;

    assign any_req_s = |bus.req;
    assign hs_s      = rsp_valid_q & bus.rsp_ready;
    assign win_idx_s = PW'(onehot_to_idx(8'(gnt_s)));

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s)
    );

    // Unpack the per-requester operand slices.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            m_s[k] = bus.req_m[k*BITS +: BITS];
            e_s[k] = bus.req_e[k*BITS +: BITS];
            n_s[k] = bus.req_n[k*BITS +: BITS];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; eng_d only matters in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req_s) state_d = ST_ISSUE; else state_d = ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.eng_d || tmo_s) state_d = ST_RESP; else state_d = ST_WAIT;
            ST_RESP:  if (hs_s) state_d = ST_IDLE; else state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and the RR pointer.
    always_comb begin
        ack_d       = {NREQ{1'b0}};
        eng_go_d    = 1'b0;
        eng_m_d     = eng_m_q;
        eng_e_d     = eng_e_q;
        eng_n_d     = eng_n_q;
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    ack_d    = gnt_s;
                    eng_go_d = 1'b1;
                    eng_m_d  = m_s[win_idx_s];
                    eng_e_d  = e_s[win_idx_s];
                    eng_n_d  = n_s[win_idx_s];
                    rsp_id_d = win_idx_s;
                    ptr_d    = (win_idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : win_idx_s + PW'(1);
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_WAIT: begin
                if (bus.eng_d) begin
                    rsp_r_d     = bus.eng_r;
                    rsp_valid_d = 1'b1;
                end else if (tmo_s) begin
                    rsp_r_d     = {BITS{1'b0}};
                    rsp_valid_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            ST_RESP: begin
                if (hs_s) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = rsp_valid_q;
            end
        endcase
    end

    // Output and pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_q       <= {NREQ{1'b0}};
            eng_go_q    <= 1'b0;
            eng_m_q     <= {BITS{1'b0}};
            eng_e_q     <= {BITS{1'b0}};
            eng_n_q     <= {BITS{1'b0}};
            ptr_q       <= {PW{1'b0}};
            rsp_id_q    <= {PW{1'b0}};
            rsp_r_q     <= {BITS{1'b0}};
            rsp_valid_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            eng_go_q    <= eng_go_d;
            eng_m_q     <= eng_m_d;
            eng_e_q     <= eng_e_d;
            eng_n_q     <= eng_n_d;
            ptr_q       <= ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef MODEXP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign tmo_s = (state_q == ST_WAIT) && !bus.eng_d && (cnt_q == CW'(TMO_CYCLES - 1));

    // Watchdog: cleared entering WAIT, counts WAIT cycles; err is sticky.
    always_comb begin
        err_d = err_q | tmo_s;
        case (state_q)
            ST_ISSUE: cnt_d = {CW{1'b0}};
            ST_WAIT:  cnt_d = cnt_q + CW'(1);
            default:  cnt_d = cnt_q;
        endcase
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= {CW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    // Without the watchdog WAIT never times out.
    assign tmo_s   = (TMO_CYCLES < 32'sd0);
    assign bus.err = 1'b0;
`endif

    assign bus.ack       = ack_q;
    assign bus.eng_go    = eng_go_q;
    assign bus.eng_m     = eng_m_q;
    assign bus.eng_e     = eng_e_q;
    assign bus.eng_n     = eng_n_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_r     = rsp_r_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed scoreboard bench for modexp_arbiter; the bench also plays the requesters and the engine.
module tb_modexp_arbiter;

    logic clk;
    logic reset_n;

    modexp_arbiter_if #(.BITS(4), .NREQ(4)) bus ();

    modexp_arbiter #(.BITS(4), .NREQ(4), .TMO_CYCLES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [5:0] sb_q [$];
    logic [3:0] om [4];
    logic [3:0] oe [4];
    logic [3:0] on [4];

    function automatic logic [3:0] mexp(input logic [3:0] m, input logic [3:0] e, input logic [3:0] n);
        int unsigned r, b, nn;
        if (n == 4'd0) return m;
        nn = int'(n);
        r  = 1 % nn;
        b  = int'(m) % nn;
        for (int i = 0; i < 4; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return 4'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] m, input logic [3:0] e, input logic [3:0] n);
        om[k] = m; oe[k] = e; on[k] = n;
        bus.req_m[k*4 +: 4] = m;
        bus.req_e[k*4 +: 4] = e;
        bus.req_n[k*4 +: 4] = n;
        bus.req[k] = 1'b1;
    endtask

    task automatic push_exp(input int k);
        sb_q.push_back({2'(k), mexp(om[k], oe[k], on[k])});
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ack != 4'b0000) break;
        end
        chk("grant_seen", 32'(bus.ack != 4'b0000), 32'd1);
    endtask

    task automatic pop_cmp(input string tag);
        logic [5:0] ex;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            ex = sb_q.pop_front();
            chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(ex[5:4]));
            chk({tag, "_rsp_r"}, 32'(bus.rsp_r), 32'(ex[3:0]));
        end
    endtask

    // Called in the ack cycle: checks the issue, plays the engine, then consumes the response.
    task automatic serve(input int k, input int lat, input bit spur, input int hold, input bit drop);
        chk("ack", 32'(bus.ack), 32'd1 << k);
        chk("go_with_ack", 32'(bus.eng_go), 32'd1);
        chk("eng_m", 32'(bus.eng_m), 32'(om[k]));
        chk("eng_e", 32'(bus.eng_e), 32'(oe[k]));
        chk("eng_n", 32'(bus.eng_n), 32'(on[k]));
        if (drop) bus.req[k] = 1'b0;
        if (spur) begin
            bus.eng_d = 1'b1;
            bus.eng_r = 4'hf;
        end
        tick();
        bus.eng_d = 1'b0;
        chk("ack_pulse", 32'(bus.ack), 32'd0);
        chk("go_pulse", 32'(bus.eng_go), 32'd0);
        chk("busy_no_rsp", 32'(bus.rsp_valid), 32'd0);
        repeat (lat) tick();
        if (hold > 0) bus.rsp_ready = 1'b0;
        bus.eng_r = mexp(bus.eng_m, bus.eng_e, bus.eng_n);
        bus.eng_d = 1'b1;
        tick();
        bus.eng_d = 1'b0;
        bus.eng_r = 4'h0;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        pop_cmp("job");
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_r", 32'(bus.rsp_r), 32'(mexp(om[k], oe[k], on[k])));
            chk("bp_no_ack", 32'(bus.ack), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req       = 4'b0000;
        bus.req_m     = 16'h0000;
        bus.req_e     = 16'h0000;
        bus.req_n     = 16'h0000;
        bus.eng_d     = 1'b0;
        bus.eng_r     = 4'h0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_go", 32'(bus.eng_go), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_eng_m", 32'(bus.eng_m), 32'd0);
        chk("rst_rsp_r", 32'(bus.rsp_r), 32'd0);
        reset_n = 1'b1;
        tick();

        // Contention: all four held, grants 0,1,2,3,0.
        set_req(0, 4'd2, 4'd3, 4'd11);
        set_req(1, 4'd3, 4'd2, 4'd13);
        set_req(2, 4'd4, 4'd5, 4'd9);
        set_req(3, 4'd5, 4'd7, 4'd15);
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        wait_ack(); serve(0, 1, 1'b0, 0, 1'b0);
        wait_ack(); serve(1, 1, 1'b0, 0, 1'b0);
        wait_ack(); serve(2, 1, 1'b0, 0, 1'b0);
        wait_ack(); serve(3, 1, 1'b0, 0, 1'b0);
        wait_ack(); serve(0, 1, 1'b0, 0, 1'b0);
        bus.req = 4'b0000;

        // Single job on requester 2: 3^3 mod 7 = 6.
        set_req(2, 4'd3, 4'd3, 4'd7);
        push_exp(2);
        wait_ack(); serve(2, 2, 1'b0, 0, 1'b1);

        // Zero modulus is forwarded untouched.
        set_req(0, 4'd5, 4'd2, 4'd0);
        push_exp(0);
        wait_ack(); serve(0, 0, 1'b0, 0, 1'b1);

        // Backpressure: pointer at 1, so 3 wins; 0 must wait for the handshake.
        set_req(0, 4'd6, 4'd2, 4'd7);
        set_req(3, 4'd7, 4'd3, 4'd10);
        push_exp(3); push_exp(0);
        wait_ack(); serve(3, 1, 1'b0, 10, 1'b1);
        wait_ack(); serve(0, 1, 1'b0, 0, 1'b1);

        // Spurious done in IDLE, then in the ISSUE cycle.
        bus.eng_d = 1'b1;
        bus.eng_r = 4'h9;
        tick();
        bus.eng_d = 1'b0;
        chk("spur_idle_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("spur_idle_valid2", 32'(bus.rsp_valid), 32'd0);
        set_req(1, 4'd9, 4'd2, 4'd11);
        push_exp(1);
        wait_ack(); serve(1, 1, 1'b1, 0, 1'b1);

`ifdef MODEXP_ARB_TIMEOUT_EN
        // Watchdog: engine stays silent, err after 8 WAIT cycles with a zero result.
        set_req(2, 4'd2, 4'd3, 4'd5);
        sb_q.push_back({2'd2, 4'd0});
        wait_ack();
        chk("tmo_ack", 32'(bus.ack), 32'd4);
        bus.req[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("tmo_err_early", 32'(bus.err), 32'd0);
        end
        tick();
        chk("tmo_err", 32'(bus.err), 32'd1);
        chk("tmo_valid", 32'(bus.rsp_valid), 32'd1);
        pop_cmp("tmo");
        tick();
        chk("tmo_cleared", 32'(bus.rsp_valid), 32'd0);
        chk("tmo_err_sticky", 32'(bus.err), 32'd1);
`else
        // Long engine latency never raises err.
        set_req(2, 4'd2, 4'd3, 4'd5);
        push_exp(2);
        wait_ack(); serve(2, 20, 1'b0, 0, 1'b1);
        chk("no_wdog_err", 32'(bus.err), 32'd0);
`endif

        // Reset while WAITing on a requester 2 job (pointer then at 3).
        set_req(2, 4'd7, 4'd5, 4'd13);
        wait_ack();
        chk("rw_ack", 32'(bus.ack), 32'd4);
        bus.req[2] = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rw_ack0", 32'(bus.ack), 32'd0);
        chk("rw_go0", 32'(bus.eng_go), 32'd0);
        chk("rw_valid0", 32'(bus.rsp_valid), 32'd0);
        chk("rw_err0", 32'(bus.err), 32'd0);
        chk("rw_eng_m0", 32'(bus.eng_m), 32'd0);
        chk("rw_eng_e0", 32'(bus.eng_e), 32'd0);
        chk("rw_eng_n0", 32'(bus.eng_n), 32'd0);
        chk("rw_rsp_id0", 32'(bus.rsp_id), 32'd0);
        bus.eng_d = 1'b1;
        bus.eng_r = 4'h5;
        tick();
        bus.eng_d = 1'b0;
        tick();
        chk("rw_stale_done", 32'(bus.rsp_valid), 32'd0);
        set_req(1, 4'd4, 4'd3, 4'd6);
        set_req(3, 4'd3, 4'd4, 4'd14);
        push_exp(1); push_exp(3);
        wait_ack(); serve(1, 1, 1'b0, 0, 1'b1);
        wait_ack(); serve(3, 1, 1'b0, 0, 1'b1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/modexp_arbiter.md
MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 Parameter BITS, default 4, operand/result width of the shared modular-exponentiation engine.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter TMO_CYCLES, default 255, engine watchdog limit; used only when MODEXP_ARB_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 req  in  NREQ  per-requester job request; level, held until ack.
REQ-007 req_m / req_e / req_n  in  NREQ*BITS each  packed message/exponent/modulus; slice k belongs to requester k.
REQ-008 ack  out  NREQ  one-hot, one-cycle pulse; job of requester k accepted.
REQ-009 eng_go  out  1  one-cycle start pulse to the engine.
REQ-010 eng_m / eng_e / eng_n  out  BITS each  registered operands to the engine.
REQ-011 eng_r  in  BITS  engine result; eng_d  in  1  engine done pulse.
REQ-012 rsp_valid  out  1  result available; rsp_id  out  $clog2(NREQ)  owner; rsp_r  out  BITS  result.
REQ-013 rsp_ready  in  1  consumer accepts the response when rsp_valid and rsp_ready are both high.
REQ-014 err  out  1  watchdog expiry flag (tied 0 without MODEXP_ARB_TIMEOUT_EN).

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; exactly one job in flight.
REQ-016 IDLE: any req high -> round-robin pick of winner w, starting at requester after last grant; latch req_*[w] into eng_*; pulse ack[w]; go to ISSUE next cycle.
REQ-017 ISSUE: eng_go high for exactly one cycle; go to WAIT.
REQ-018 WAIT: eng_m/e/n held stable; on eng_d capture eng_r into rsp_r, set rsp_valid, go to RESP.
REQ-019 RESP: hold rsp_valid/rsp_id/rsp_r stable until handshake; on handshake clear rsp_valid, return to IDLE.
REQ-020 Min latency req->rsp_valid: 3 cycles plus engine latency; back-to-back grant earliest one cycle after response handshake.
REQ-021 Round-robin pointer updates only on ack; after reset the highest priority is requester 0.
REQ-022 req deasserted before ack: no grant, no side effect; req changes after ack are ignored for the in-flight job.
REQ-023 eng_d outside WAIT is ignored; eng_d coincident with the eng_go cycle is ignored.
REQ-024 eng_n == 0: arbiter forwards job unchanged; result is whatever engine returns (no check).

Reset
REQ-025 reset_n low at a clock edge: FSM -> IDLE; ack, eng_go, rsp_valid, err -> 0; eng_*, rsp_r, rsp_id -> 0; RR pointer -> 0.
REQ-026 Reset mid-job abandons it with no response; a later eng_d from the abandoned job is ignored per REQ-023.

Configuration
REQ-027 MODEXP_ARB_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle; reaching TMO_CYCLES without eng_d sets err sticky until reset, produces response rsp_r = 0 for the owner, enters RESP.
REQ-028 MODEXP_ARB_TIMEOUT_EN undefined: no counter, err constant 0, WAIT waits indefinitely.

Structure
REQ-029 Package modexp_pkg holds the default BITS constant and the FSM state enumeration, shared with the engine wrapper.
REQ-030 Sub-module rr_arbiter (NREQ-wide, request vector + pointer in, one-hot grant out) implements REQ-016/REQ-021 selection.

Verification
REQ-031 Single: req[2]=1, m=3,e=3,n=7, engine returns 6 -> ack[2] pulse, one eng_go, rsp_id=2, rsp_r=6.
REQ-032 Contention: req=4'b1111 held -> grants in order 0,1,2,3,0; each ack exactly once per response handshake.
REQ-033 Backpressure: rsp_ready low 10 cycles -> rsp_valid/rsp_r stable, no new ack until handshake.
REQ-034 Spurious done: eng_d pulsed in IDLE and in ISSUE cycle -> no rsp_valid.
REQ-035 Reset in WAIT: reset_n low one cycle -> all outputs 0; subsequent eng_d ignored; next req[1] granted first after requester 0 idle.
REQ-036 Timeout (macro on, TMO_CYCLES=8): engine never asserts eng_d -> err=1 after 8 WAIT cycles, rsp_r=0 for owner, err stays 1.
